// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
//   Shared definitions for the instruction-memory loader. The fetch stage and
//   the top level also pull INSTR_W from here, so the instruction width is
//   declared in exactly one place.
//
//   Contents:
//     BYTES_PER_INSTR  bytes streamed per instruction (big-endian)
//     INSTR_W          instruction width in bits (48)
//     loader_state_t   loader FSM state encoding
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    localparam int BYTES_PER_INSTR = 6;
    localparam int INSTR_W         = BYTES_PER_INSTR * 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_byte_packer.sv
// -----------------------------------------------------------------------------
// instr_byte_packer
//   Assembles one instruction word from a byte stream, first byte ending up in
//   the most significant byte. Keeps a byte counter so the owner knows when
//   the current shift completes a word.
//
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset; discards partial word
//     clear      in   restart assembly (new session)
//     shift_en   in   accept byte_in this cycle
//     byte_in    in   8-bit stream byte
//     word_out   out  INSTR_W assembly register
//     last_byte  out  high while the next accepted byte completes a word
// -----------------------------------------------------------------------------
module instr_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_out,
    output logic               last_byte
);

    localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_INSTR - 1);

    logic [2:0]         count_q;
    logic [INSTR_W-1:0] word_q;

    assign last_byte = (count_q == LAST_IDX);
    assign word_out  = word_q;

    // Assembly stage: shift left one byte per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            word_q  <= '0;
        end else if (clear) begin
            count_q <= '0;
            word_q  <= '0;
        end else if (shift_en) begin
            word_q  <= {word_q[INSTR_W-9:0], byte_in};
            // Wrap the counter on the completing byte so the next word
            // starts at count 0 without needing an extra clear.
            count_q <= last_byte ? 3'd0 : count_q + 3'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Loads a program image into the instruction memory from a byte stream.
//   Six big-endian bytes form one 48-bit instruction, written to consecutive
//   word addresses from 0. cpu_hold is ORed into the fetch-stage reset by the
//   top level, so fetch restarts at address 0 only once the image is complete.
//
//   Parameters:
//     ADDR_W       instruction-memory word-address width (depth 2^ADDR_W)
//
//   Ports:
//     clk          in   system clock (same as fetch stage)
//     rst          in   synchronous active-high reset
//     start        in   begin a session (sampled only when idle)
//     num_words    in   instruction count, latched with start
//     byte_valid   in   stream byte available
//     byte_data    in   stream byte
//     byte_ready   out  loader accepts a byte this cycle
//     mem_wren     out  instruction-memory write enable
//     mem_address  out  write word address
//     mem_data     out  write data
//     cpu_hold     out  hold fetch in reset during a session
//     busy         out  loader not idle
//     done         out  one-cycle end-of-session pulse
// -----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W:0]    num_words,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               mem_wren,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [INSTR_W-1:0] mem_data,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    // Limit the session to the memory depth so the address never wraps.
    function automatic logic [ADDR_W:0] sat_words(input logic [ADDR_W:0] req);
        return (req > MAX_WORDS) ? MAX_WORDS : req;
    endfunction

    loader_state_t      state_q;
    loader_state_t      state_d;
    logic [ADDR_W:0]    words_left_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic [INSTR_W-1:0] mem_data_q;
    logic [INSTR_W-1:0] word_out;
    logic               last_byte;
    logic               accept_start;
    logic               xfer;
    logic               unused_word_top;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign xfer         = (state_q == ST_COLLECT) && byte_valid;

    // The completed word is captured as {word_out[39:0], byte_data}, so the
    // oldest byte of the packer register is never read here.
    assign unused_word_top = ^word_out[INSTR_W-1:INSTR_W-8];

    instr_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_start),
        .shift_en  (xfer),
        .byte_in   (byte_data),
        .word_out  (word_out),
        .last_byte (last_byte)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (sat_words(num_words) == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (byte_valid && last_byte) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = (words_left_q == ONE_WORD) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control stage: FSM, address counter and remaining-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            words_left_q <= '0;
            addr_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                words_left_q <= sat_words(num_words);
                addr_q       <= '0;
            end else if (state_q == ST_WRITE) begin
                words_left_q <= words_left_q - ONE_WORD;
                addr_q       <= addr_q + ONE_ADDR;
            end
        end
    end

    // Write-port stage: latched as the word completes so address and data are
    // valid for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else if (xfer && last_byte) begin
            mem_address_q <= addr_q;
            mem_data_q    <= {word_out[INSTR_W-9:0], byte_data};
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign byte_ready  = (state_q == ST_COLLECT);
    assign mem_wren    = (state_q == ST_WRITE);
    assign busy        = (state_q != ST_IDLE);
    assign cpu_hold    = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;

    // DUT a: ADDR_W = 8
    logic        a_start;
    logic [8:0]  a_num_words;
    logic        a_byte_ready, a_mem_wren, a_cpu_hold, a_busy, a_done;
    logic [7:0]  a_mem_address;
    logic [47:0] a_mem_data;

    // DUT b: ADDR_W = 2 (clamp scenario)
    logic        b_start;
    logic [2:0]  b_num_words;
    logic        b_byte_ready, b_mem_wren, b_cpu_hold, b_busy, b_done;
    logic [1:0]  b_mem_address;
    logic [47:0] b_mem_data;

    instr_mem_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .num_words(a_num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(a_byte_ready),
        .mem_wren(a_mem_wren), .mem_address(a_mem_address), .mem_data(a_mem_data),
        .cpu_hold(a_cpu_hold), .busy(a_busy), .done(a_done)
    );

    instr_mem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .num_words(b_num_words),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_byte_ready),
        .mem_wren(b_mem_wren), .mem_address(b_mem_address), .mem_data(b_mem_data),
        .cpu_hold(b_cpu_hold), .busy(b_busy), .done(b_done)
    );

    int sel = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc++;

    logic        cur_ready, cur_wren, cur_hold, cur_busy, cur_done;
    logic [7:0]  cur_addr;
    logic [47:0] cur_data;
    assign cur_ready = (sel == 0) ? a_byte_ready : b_byte_ready;
    assign cur_wren  = (sel == 0) ? a_mem_wren   : b_mem_wren;
    assign cur_hold  = (sel == 0) ? a_cpu_hold   : b_cpu_hold;
    assign cur_busy  = (sel == 0) ? a_busy       : b_busy;
    assign cur_done  = (sel == 0) ? a_done       : b_done;
    assign cur_addr  = (sel == 0) ? a_mem_address : {6'b0, b_mem_address};
    assign cur_data  = (sel == 0) ? a_mem_data   : b_mem_data;

    // Observation logs of the selected DUT
    logic [7:0]  wr_addr_q[$];
    logic [47:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic        wr_rdy_q[$];
    int          done_cyc_q[$];
    logic        hold_log[int];
    logic        busy_log[int];

    always @(negedge clk) begin
        if (cur_wren === 1'b1) begin
            wr_addr_q.push_back(cur_addr);
            wr_data_q.push_back(cur_data);
            wr_cyc_q.push_back(cyc);
            wr_rdy_q.push_back(cur_ready);
        end
        if (cur_done === 1'b1) done_cyc_q.push_back(cyc);
        hold_log[cyc] = cur_hold;
        busy_log[cyc] = cur_busy;
    end

    // Reference model: expected memory image from the byte stream
    logic [7:0]  tx_q[$];
    logic [47:0] exp_words[$];

    function automatic void build_model(input int n, input int depth);
        int cnt;
        cnt = (n < depth) ? n : depth;
        exp_words.delete();
        for (int i = 0; i < cnt; i++) begin
            logic [47:0] w;
            w = '0;
            for (int k = 0; k < 6; k++) w = (w << 8) | 48'(tx_q[6*i+k]);
            exp_words.push_back(w);
        end
    endfunction

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); wr_rdy_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) a_start = v; else b_start = v;
    endtask

    // Start accepted at the posedge ending interval t; returns with cycle t+1 open.
    task automatic pulse_start(input int n, output int t);
        @(posedge clk); #1;
        a_num_words = 9'(n);
        b_num_words = 3'(n);
        set_start(1'b1);
        t = cyc;
        @(posedge clk); #1;
        set_start(1'b0);
    endtask

    task automatic stream(input bit gaps, input int inject_at, input int budget, output int sent);
        int  i;
        bit  over;
        i = 0; sent = 0; over = 0;
        while (sent < int'(tx_q.size()) && i < budget && !over) begin
            byte_valid = (gaps && !cur_wren) ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = tx_q[sent];
            if (i == inject_at) set_start(1'b1);
            @(negedge clk);
            if (byte_valid && cur_ready) sent++;
            if (sent > 0 && !cur_busy) over = 1;
            @(posedge clk); #1;
            set_start(1'b0);
            i++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (cur_busy === 1'b0) ok = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_start = 1'b1; b_start = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
        a_num_words = 9'd3; b_num_words = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({a_byte_ready, a_mem_wren, a_cpu_hold, a_busy, a_done} !== 5'b0) begin n_fail++; $display("FAIL reset_a_ctrl: got %b expected 00000", {a_byte_ready, a_mem_wren, a_cpu_hold, a_busy, a_done}); end
        n_checks++; if (a_mem_address !== 8'h0) begin n_fail++; $display("FAIL reset_a_addr: got %h expected 0", a_mem_address); end
        n_checks++; if (a_mem_data !== 48'h0) begin n_fail++; $display("FAIL reset_a_data: got %h expected 0", a_mem_data); end
        n_checks++; if ({b_byte_ready, b_mem_wren, b_cpu_hold, b_busy, b_done} !== 5'b0) begin n_fail++; $display("FAIL reset_b_ctrl: got %b expected 00000", {b_byte_ready, b_mem_wren, b_cpu_hold, b_busy, b_done}); end
        n_checks++; if (b_mem_address !== 2'h0) begin n_fail++; $display("FAIL reset_b_addr: got %h expected 0", b_mem_address); end
        n_checks++; if (b_mem_data !== 48'h0) begin n_fail++; $display("FAIL reset_b_data: got %h expected 0", b_mem_data); end
        @(posedge clk); #1;
        rst = 1'b0; a_start = 1'b0; b_start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy a=%b b=%b expected 0", a_busy, b_busy); end
        n_checks++; if (a_byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ready: got %b expected 0", a_byte_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_two_word();
        int t, sent, w;
        bit ok;
        sel = 0; clear_logs();
        tx_q.delete();
        for (int i = 1; i <= 12; i++) tx_q.push_back(8'(i));
        build_model(2, 256);
        pulse_start(2, t);
        n_checks++; if (cur_ready !== 1'b1 || cur_hold !== 1'b1) begin n_fail++; $display("FAIL two_start_t1: got ready=%b hold=%b expected 1 1", cur_ready, cur_hold); end
        stream(0, -1, 40, sent);
        n_checks++; if (sent !== 12) begin n_fail++; $display("FAIL two_sent: got %0d expected 12", sent); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_idle_timeout: got busy expected idle"); end
        n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL two_wr_count: got %0d expected 2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[i] !== 8'(i)) begin n_fail++; $display("FAIL two_addr%0d: got %h expected %h", i, wr_addr_q[i], i); end
            n_checks++; if (wr_data_q[i] !== exp_words[i]) begin n_fail++; $display("FAIL two_data%0d: got %h expected %h", i, wr_data_q[i], exp_words[i]); end
        end
        if (wr_cyc_q.size() == 2) begin
            w = wr_cyc_q[1];
            n_checks++; if (wr_cyc_q[0] != t + 7) begin n_fail++; $display("FAIL two_first_wr_cyc: got %0d expected %0d", wr_cyc_q[0], t + 7); end
            n_checks++; if (w != t + 14) begin n_fail++; $display("FAIL two_last_wr_cyc: got %0d expected %0d", w, t + 14); end
            n_checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != w + 1) begin n_fail++; $display("FAIL two_done: got count %0d expected one pulse at %0d", done_cyc_q.size(), w + 1); end
            n_checks++; if (hold_log[w+1] !== 1'b1) begin n_fail++; $display("FAIL two_hold_done: got %b expected 1", hold_log[w+1]); end
            n_checks++; if (hold_log[w+2] !== 1'b0 || busy_log[w+2] !== 1'b0) begin n_fail++; $display("FAIL two_release: got hold=%b busy=%b expected 0 0", hold_log[w+2], busy_log[w+2]); end
        end
    endtask

    task automatic test_gaps();
        int t, sent;
        bit ok;
        sel = 0; clear_logs();
        fill_random(12);
        build_model(2, 256);
        pulse_start(2, t);
        stream(1, -1, 300, sent);
        n_checks++; if (sent !== 12) begin n_fail++; $display("FAIL gaps_sent: got %0d expected 12", sent); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gaps_idle_timeout: got busy expected idle"); end
        n_checks++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL gaps_wr_count: got %0d expected 2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[i] !== 8'(i)) begin n_fail++; $display("FAIL gaps_addr%0d: got %h expected %h", i, wr_addr_q[i], i); end
            n_checks++; if (wr_data_q[i] !== exp_words[i]) begin n_fail++; $display("FAIL gaps_data%0d: got %h expected %h", i, wr_data_q[i], exp_words[i]); end
            n_checks++; if (wr_rdy_q[i] !== 1'b0) begin n_fail++; $display("FAIL gaps_ready_in_write%0d: got %b expected 0", i, wr_rdy_q[i]); end
        end
        n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL gaps_done_count: got %0d expected 1", done_cyc_q.size()); end
    endtask

    task automatic test_zero();
        int t;
        bit ok;
        sel = 0; clear_logs();
        pulse_start(0, t);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_idle_timeout: got busy expected idle"); end
        n_checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != t + 1) begin n_fail++; $display("FAIL zero_done: got count %0d expected one pulse at %0d", done_cyc_q.size(), t + 1); end
        n_checks++; if (hold_log[t+1] !== 1'b1 || hold_log[t+2] !== 1'b0) begin n_fail++; $display("FAIL zero_hold: got %b%b expected 10", hold_log[t+1], hold_log[t+2]); end
        n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_wren: got %0d writes expected 0", wr_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        int t, sent;
        bit ok;
        sel = 0; clear_logs();
        fill_random(3);
        pulse_start(2, t);
        stream(0, -1, 20, sent);
        n_checks++; if (sent !== 3) begin n_fail++; $display("FAIL mid_sent: got %0d expected 3", sent); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (cur_hold !== 1'b0 || cur_busy !== 1'b0 || cur_ready !== 1'b0) begin n_fail++; $display("FAIL mid_after_rst: got hold=%b busy=%b ready=%b expected 0 0 0", cur_hold, cur_busy, cur_ready); end
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL mid_no_write: got %0d writes expected 0", wr_addr_q.size()); end
        clear_logs();
        fill_random(6);
        build_model(1, 256);
        pulse_start(1, t);
        stream(0, -1, 20, sent);
        wait_idle(ok);
        n_checks++; if (!ok || wr_addr_q.size() != 1) begin n_fail++; $display("FAIL mid_new_count: got %0d writes expected 1", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1) begin
            n_checks++; if (wr_addr_q[0] !== 8'h0) begin n_fail++; $display("FAIL mid_new_addr: got %h expected 00", wr_addr_q[0]); end
            n_checks++; if (wr_data_q[0] !== exp_words[0]) begin n_fail++; $display("FAIL mid_new_data: got %h expected %h", wr_data_q[0], exp_words[0]); end
        end
    endtask

    task automatic test_clamp();
        int t, sent;
        bit ok;
        sel = 1; clear_logs();
        fill_random(42);
        build_model(7, 4);
        pulse_start(7, t);
        stream(1, 10, 300, sent);
        n_checks++; if (sent !== 24) begin n_fail++; $display("FAIL clamp_sent: got %0d expected 24", sent); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_idle_timeout: got busy expected idle"); end
        n_checks++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL clamp_wr_count: got %0d expected 4", wr_addr_q.size()); end
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            n_checks++; if (wr_addr_q[i] !== 8'(i)) begin n_fail++; $display("FAIL clamp_addr%0d: got %h expected %h", i, wr_addr_q[i], i); end
            n_checks++; if (wr_data_q[i] !== exp_words[i]) begin n_fail++; $display("FAIL clamp_data%0d: got %h expected %h", i, wr_data_q[i], exp_words[i]); end
        end
        n_checks++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL clamp_done_count: got %0d expected 1", done_cyc_q.size()); end
        sel = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_word();
        test_gaps();
        test_zero();
        test_reset_mid();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
